// File: rtl/carry_look_ahead_pkg.sv
// Purpose : shared constants for the carry-look-ahead adder slice.
// Ports   : none (package only).
package carry_look_ahead_pkg;

    // Width of one first-level look-ahead group.
    localparam int GROUP_W = 4;

    // Largest number of groups the second-level unit is built for.
    localparam int MAX_GROUPS = 4;

endpackage : carry_look_ahead_pkg

// File: rtl/carry_look_ahead_cla_group_4.sv
// Purpose : 4-bit carry-look-ahead group. Produces the group sum from a
//           supplied carry-in, plus group generate/propagate for the
//           second look-ahead level.
// Ports   : a, b  - 4-bit operand slices
//           cin   - carry into bit 0 of the group
//           sum   - 4-bit sum slice
//           gg    - group generate (carry out regardless of cin)
//           gp    - group propagate (cin passes straight through)
module cla_group_4
    import carry_look_ahead_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               gg,
    output logic               gp
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/cin; none depends on
    // the previous carry, so there is no ripple path inside the group.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule : cla_group_4

// File: rtl/carry_look_ahead.sv
// Purpose : registered unsigned adder {Cout,S} = A + B built from 4-bit
//           look-ahead groups and a second-level look-ahead carry unit.
//           One cycle latency, one new operand pair per cycle.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset, clears S and Cout
//           A, B  - WIDTH-bit unsigned operands
//           Cout  - registered carry out of bit WIDTH-1
//           S     - registered WIDTH-bit sum
module carry_look_ahead
    import carry_look_ahead_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Cout,
    output logic [WIDTH-1:0] S
);

    localparam int NG = WIDTH / GROUP_W;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W || NG > MAX_GROUPS) begin : g_bad_width
        $fatal(1, "carry_look_ahead: WIDTH must be 4, 8, 12 or 16");
    end

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    // Second-level look-ahead: carry into group j is
    //   OR over i<j of ( GG[i] & GP[i+1] & ... & GP[j-1] ).
    // The carry-in term of the sum of products drops out because the
    // adder has no external carry-in.
    always_comb begin
        logic acc;
        logic prod;
        grp_c = '0;
        for (int j = 1; j <= NG; j++) begin
            acc = 1'b0;
            for (int i = 0; i < j; i++) begin
                prod = grp_g[i];
                for (int k = i + 1; k < j; k++) begin
                    prod = prod & grp_p[k];
                end
                acc = acc | prod;
            end
            grp_c[j] = acc;
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group_4 u_grp (
            .a   (A[gi*GROUP_W +: GROUP_W]),
            .b   (B[gi*GROUP_W +: GROUP_W]),
            .cin (grp_c[gi]),
            .sum (s_d[gi*GROUP_W +: GROUP_W]),
            .gg  (grp_g[gi]),
            .gp  (grp_p[gi])
        );
    end

    assign cout_d = grp_c[NG];

    // Output register; reset clears the result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule : carry_look_ahead

// File: tb/tb_carry_look_ahead.sv
// Purpose : self-checking bench for carry_look_ahead at WIDTH=4 and WIDTH=16.
// Ports   : none.
module tb_carry_look_ahead;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [3:0]  s4;
    logic        cout4;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] s16;
    logic        cout16;

    int checks;
    int errors;

    carry_look_ahead #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4),
        .B     (b4),
        .Cout  (cout4),
        .S     (s4)
    );

    carry_look_ahead #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a16),
        .B     (b16),
        .Cout  (cout16),
        .S     (s16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one operand pair on each width at the falling edge, then check
    // the registered result just after the next rising edge against plain
    // integer addition.
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic [15:0] wa, input logic [15:0] wb);
        logic [31:0] exp4;
        logic [31:0] exp16;
        @(negedge clk);
        a4  = a;
        b4  = b;
        a16 = wa;
        b16 = wb;
        exp4  = 32'(int'(a) + int'(b));
        exp16 = 32'(int'(wa) + int'(wb));
        @(posedge clk);
        #1;
        check("sum4",  32'({cout4, s4}),   exp4);
        check("sum16", 32'({cout16, s16}), exp16);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a4  = 4'hF;
        b4  = 4'hF;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;

        // Reset held with maximal operands: outputs must stay clear.
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check("rst4",  32'({cout4, s4}),   32'h0);
            check("rst16", 32'({cout16, s16}), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        step(4'h4, 4'h1, 16'h0004, 16'h0001);
        step(4'h0, 4'h0, 16'h0000, 16'h0000);
        step(4'hF, 4'h1, 16'hFFFF, 16'h0001);
        step(4'h5, 4'hA, 16'h5555, 16'hAAAA);
        step(4'hF, 4'hF, 16'hFFFF, 16'hFFFF);
        step(4'hF, 4'h1, 16'h0FFF, 16'h0001);

        // Reset between edges with 9+9 pending: clears at once, and the
        // pending 2/carry result must never show up.
        @(negedge clk);
        a4  = 4'h9;
        b4  = 4'h9;
        a16 = 16'h9999;
        b16 = 16'h9999;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst4",  32'({cout4, s4}),   32'h0);
        check("midrst16", 32'({cout16, s16}), 32'h0);
        @(posedge clk);
        #1;
        check("midrst4_edge",  32'({cout4, s4}),   32'h0);
        check("midrst16_edge", 32'({cout16, s16}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a4  = 4'h3;
        b4  = 4'h4;
        a16 = 16'h1234;
        b16 = 16'h4321;
        @(posedge clk);
        #1;
        check("release4",  32'({cout4, s4}),   32'h7);
        check("release16", 32'({cout16, s16}), 32'h5555);

        // Exhaustive 4-bit pairs back to back; the wide instance gets random pairs.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                step(4'(ia), 4'(ib), 16'($urandom), 16'($urandom));
            end
        end

        // Random pairs on both widths.
        for (int n = 0; n < 10000; n++) begin
            step(4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_carry_look_ahead
